// File: rtl/mat_row_store.sv
`default_nettype none
// ============================================================================
// Module   : mat_row_store
// Brief    : SIZE x SIZE complex matrix store: host row load, engine row or
//            column reads with write-back, then row drain to the host.
// Revision : 1.0 - initial release
// ============================================================================
module mat_row_store #(
  parameter int SIZE  = 4,
  parameter int WIDTH = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_i,
  input  logic [SIZE*2*WIDTH-1:0]       load_row_i,
  input  logic                          load_valid_i,
  output logic                          load_ready_o,
  input  logic [$clog2(SIZE)-1:0]       rd_addr_i,
  input  logic                          rd_addr_valid_i,
  input  logic                          rd_col_i,
  output logic [SIZE*2*WIDTH-1:0]       rd_row_o,
  output logic [$clog2(SIZE)-1:0]       rd_addr_o,
  output logic                          rd_valid_o,
  input  logic [SIZE*2*WIDTH-1:0]       wr_row_i,
  input  logic [$clog2(SIZE)-1:0]       wr_addr_i,
  input  logic                          wr_valid_i,
  output logic                          wr_ready_o,
  input  logic                          drain_start_i,
  output logic [SIZE*2*WIDTH-1:0]       drain_row_o,
  output logic [$clog2(SIZE)-1:0]       drain_addr_o,
  output logic                          drain_valid_o,
  input  logic                          drain_ready_i,
  output logic                          full_o,
  output logic                          busy_o
);

  localparam int AW = $clog2(SIZE);
  localparam int EW = 2 * WIDTH;
  localparam int RW = SIZE * EW;

  localparam logic [AW:0] c_last_row = (AW+1)'(SIZE - 1);
  localparam logic [AW:0] c_one      = (AW+1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SERVE = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW:0]     r_cnt;
  logic [AW:0]     w_cnt_nxt;

  logic [RW-1:0]   r_mem [SIZE];
  logic            w_mem_we;
  logic [AW-1:0]   w_mem_waddr;
  logic [RW-1:0]   w_mem_wdata;

  logic            r_rd_valid;
  logic [AW-1:0]   r_rd_addr;
  logic [RW-1:0]   r_rd_row;
  logic [RW-1:0]   w_col;
  logic            w_rd_req;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_mem_we      = 1'b0;
    w_mem_waddr   = '0;
    w_mem_wdata   = load_row_i;
    load_ready_o  = 1'b0;
    wr_ready_o    = 1'b0;
    full_o        = 1'b0;
    drain_valid_o = 1'b0;
    busy_o        = (r_state != ST_IDLE);

    case (r_state)
      ST_IDLE: begin
        load_ready_o = 1'b1;
        if (load_valid_i) begin
          w_mem_we    = 1'b1;
          w_cnt_nxt   = c_one;
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        load_ready_o = 1'b1;
        if (load_valid_i) begin
          w_mem_we    = 1'b1;
          w_mem_waddr = r_cnt[AW-1:0];
          if (r_cnt == c_last_row) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_SERVE;
          end else begin
            w_cnt_nxt = r_cnt + c_one;
          end
        end
      end
      ST_SERVE: begin
        full_o     = 1'b1;
        wr_ready_o = 1'b1;
        if (wr_valid_i) begin
          w_mem_we    = 1'b1;
          w_mem_waddr = wr_addr_i;
          w_mem_wdata = wr_row_i;
        end
        if (drain_start_i) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        drain_valid_o = 1'b1;
        if (drain_ready_i) begin
          if (r_cnt == c_last_row) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_cnt_nxt = r_cnt + c_one;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Flush wins over every transition and drops any same-cycle write.
    if (flush_i) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
      w_mem_we    = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && w_mem_we) begin
      r_mem[w_mem_waddr] <= w_mem_wdata;
    end
  end

  // Column k of the response gathers element rd_addr_i of every stored row.
  for (genvar k = 0; k < SIZE; k++) begin : g_col
    assign w_col[k*EW +: EW] = r_mem[k][rd_addr_i*EW +: EW];
  end

  assign w_rd_req = rd_addr_valid_i && (r_state == ST_SERVE) && !flush_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rd_valid <= 1'b0;
      r_rd_addr  <= '0;
      r_rd_row   <= '0;
    end else begin
      r_rd_valid <= w_rd_req;
      r_rd_addr  <= rd_addr_i;
      if (w_rd_req) begin
        r_rd_row <= rd_col_i ? w_col : r_mem[rd_addr_i];
      end
    end
  end

  assign rd_valid_o   = r_rd_valid;
  assign rd_addr_o    = r_rd_addr;
  assign rd_row_o     = r_rd_row;
  assign drain_row_o  = r_mem[r_cnt[AW-1:0]];
  assign drain_addr_o = r_cnt[AW-1:0];

endmodule
`default_nettype wire

// File: tb/tb_mat_row_store.sv
`default_nettype none
// ============================================================================
// Module   : tb_mat_row_store
// Brief    : Scoreboard bench for mat_row_store load / serve / drain / flush.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mat_row_store;

  localparam int SIZE  = 4;
  localparam int WIDTH = 64;
  localparam int AW    = $clog2(SIZE);
  localparam int EW    = 2 * WIDTH;
  localparam int RW    = SIZE * EW;

  logic          clk_i = 1'b0;
  logic          rst_ni, flush_i;
  logic [RW-1:0] load_row_i;
  logic          load_valid_i, load_ready_o;
  logic [AW-1:0] rd_addr_i;
  logic          rd_addr_valid_i, rd_col_i;
  logic [RW-1:0] rd_row_o;
  logic [AW-1:0] rd_addr_o;
  logic          rd_valid_o;
  logic [RW-1:0] wr_row_i;
  logic [AW-1:0] wr_addr_i;
  logic          wr_valid_i, wr_ready_o;
  logic          drain_start_i;
  logic [RW-1:0] drain_row_o;
  logic [AW-1:0] drain_addr_o;
  logic          drain_valid_o, drain_ready_i;
  logic          full_o, busy_o;

  mat_row_store #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .load_row_i(load_row_i), .load_valid_i(load_valid_i), .load_ready_o(load_ready_o),
    .rd_addr_i(rd_addr_i), .rd_addr_valid_i(rd_addr_valid_i), .rd_col_i(rd_col_i),
    .rd_row_o(rd_row_o), .rd_addr_o(rd_addr_o), .rd_valid_o(rd_valid_o),
    .wr_row_i(wr_row_i), .wr_addr_i(wr_addr_i), .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
    .drain_start_i(drain_start_i), .drain_row_o(drain_row_o), .drain_addr_o(drain_addr_o),
    .drain_valid_o(drain_valid_o), .drain_ready_i(drain_ready_i),
    .full_o(full_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [AW-1:0] addr;
    logic [RW-1:0] row;
  } rsp_t;

  rsp_t          r_q[$];
  logic [RW-1:0] r_model [SIZE];
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [RW-1:0] mk_row(input int i, input int off);
    logic [RW-1:0] r;
    for (int j = 0; j < SIZE; j++) begin
      r[j*EW +: WIDTH]         = $realtobits(real'(10*i + j + off));
      r[j*EW + WIDTH +: WIDTH] = $realtobits(-real'(i));
    end
    return r;
  endfunction

  function automatic logic [RW-1:0] col_of(input int a);
    logic [RW-1:0] c;
    for (int k = 0; k < SIZE; k++) c[k*EW +: EW] = r_model[k][a*EW +: EW];
    return c;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic load_rows(input int n, input int off);
    for (int i = 0; i < n; i++) begin
      load_row_i   = mk_row(i, off);
      load_valid_i = 1'b1;
      r_model[i]   = load_row_i;
      step();
      load_valid_i = 1'b0;
    end
  endtask

  task automatic issue_rd(input int a, input logic col);
    rsp_t e;
    rd_addr_i       = AW'(a);
    rd_col_i        = col;
    rd_addr_valid_i = 1'b1;
    e.addr = AW'(a);
    e.row  = col ? col_of(a) : r_model[a];
    r_q.push_back(e);
    step();
    rd_addr_valid_i = 1'b0;
    rd_col_i        = 1'b0;
  endtask

  // Response monitor: every valid response must match the oldest expectation.
  always @(negedge clk_i) begin
    if (rst_ni === 1'b1 && rd_valid_o === 1'b1) begin
      if (r_q.size() == 0) begin
        check("rd_unexpected", 1, 0);
      end else begin
        rsp_t e;
        e = r_q.pop_front();
        check("rd_addr", rd_addr_o, e.addr);
        check("rd_row", rd_row_o, e.row);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [RW-1:0] five_row;
    logic [RW-1:0] held;
    int            idx;
    int            cyc;

    rst_ni = 1'b0; flush_i = 1'b0;
    load_row_i = '0; load_valid_i = 1'b0;
    rd_addr_i = '0; rd_addr_valid_i = 1'b0; rd_col_i = 1'b0;
    wr_row_i = '0; wr_addr_i = '0; wr_valid_i = 1'b0;
    drain_start_i = 1'b0; drain_ready_i = 1'b0;
    step();
    step();

    check("rst_load_ready", load_ready_o, 1);
    check("rst_wr_ready", wr_ready_o, 0);
    check("rst_full", full_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_rd_valid", rd_valid_o, 0);
    check("rst_rd_addr", rd_addr_o, 0);
    check("rst_rd_row", rd_row_o, 0);
    check("rst_drain_valid", drain_valid_o, 0);
    rst_ni = 1'b1;

    // Writes outside SERVE are refused.
    check("idle_wr_ready", wr_ready_o, 0);

    load_rows(SIZE, 0);
    check("load_full", full_o, 1);
    check("load_ready_serve", load_ready_o, 0);
    check("serve_busy", busy_o, 1);
    check("serve_wr_ready", wr_ready_o, 1);

    issue_rd(2, 1'b0);
    issue_rd(0, 1'b0);
    issue_rd(3, 1'b0);

    issue_rd(1, 1'b1);
    for (int k = 0; k < SIZE; k++)
      check("col1_real", rd_row_o[k*EW +: WIDTH], $realtobits(real'(10*k + 1)));
    held = rd_row_o;
    step();
    check("rd_hold_valid", rd_valid_o, 0);
    check("rd_hold_row", rd_row_o, held);

    for (int j = 0; j < SIZE; j++) begin
      five_row[j*EW +: WIDTH]         = $realtobits(5.0);
      five_row[j*EW + WIDTH +: WIDTH] = $realtobits(5.0);
    end
    wr_row_i   = five_row;
    wr_addr_i  = 2'd2;
    wr_valid_i = 1'b1;
    begin
      rsp_t e;
      rd_addr_i = 2'd2; rd_col_i = 1'b0; rd_addr_valid_i = 1'b1;
      e.addr = 2'd2; e.row = r_model[2];
      r_q.push_back(e);
      r_model[2] = five_row;
      step();
      rd_addr_valid_i = 1'b0; wr_valid_i = 1'b0;
    end
    issue_rd(2, 1'b0);
    check("wb_real", rd_row_o[WIDTH-1:0], $realtobits(5.0));
    issue_rd(2, 1'b1);
    step();

    // Drain with host ready toggling; each row must stay put while stalled.
    drain_start_i = 1'b1;
    issue_rd(0, 1'b0);
    drain_start_i = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < SIZE && cyc < 40) begin
      drain_ready_i = (cyc % 2 == 0);
      check("drain_valid", drain_valid_o, 1);
      check("drain_addr", drain_addr_o, idx);
      check("drain_row", drain_row_o, r_model[idx]);
      step();
      if (drain_ready_i) idx++;
      cyc++;
    end
    drain_ready_i = 1'b0;
    check("drain_count", idx, SIZE);
    check("drain_busy", busy_o, 0);
    check("drain_valid_end", drain_valid_o, 0);
    check("drain_load_ready", load_ready_o, 1);

    load_rows(2, 100);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    check("flush_load_busy", busy_o, 0);
    check("flush_load_ready", load_ready_o, 1);

    load_rows(SIZE, 200);
    check("reload_full", full_o, 1);
    issue_rd(0, 1'b0);
    issue_rd(1, 1'b0);
    issue_rd(3, 1'b1);
    step();

    // Read and write alongside flush: no response, write dropped.
    rd_addr_i = 2'd1; rd_addr_valid_i = 1'b1;
    wr_row_i = '0; wr_addr_i = 2'd1; wr_valid_i = 1'b1;
    flush_i = 1'b1;
    step();
    flush_i = 1'b0; rd_addr_valid_i = 1'b0; wr_valid_i = 1'b0;
    check("flush_rd_valid", rd_valid_o, 0);
    check("flush_serve_busy", busy_o, 0);
    check("flush_full", full_o, 0);
    check("flush_mem_kept", dut.r_mem[1], r_model[1]);
    step();
    step();
    check("sb_empty", r_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
